vx_commit_unit: RTL



---
 rtl/vx_commit_pkg.sv | 34 +++
 rtl/vx_commit_unit_arbiter.sv | 78 +++++++
 rtl/vx_commit_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vx_commit_pkg.sv
// Shared widths, helpers and defaults for the commit unit slice.
package vx_commit_pkg;

    // The popcount helper works on a fixed, wide vector. Callers zero-extend
    // their vector into it, and synthesis trims the unused constant bits.
    localparam int POPC_W     = 1024;
    localparam int POPC_CNT_W = 11;

    // Warp-id width. It is never narrower than one bit, even for single-warp cores.
    function automatic int wid_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    // Width needed to hold a count from 0 to num_ch*num_threads inclusive.
    function automatic int csz_width(input int num_ch, input int num_threads);
        return $clog2(num_ch * num_threads + 1);
    endfunction

    // Index width for an N-entry selection. It is never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Count of set bits in v.
    function automatic logic [POPC_CNT_W-1:0] popcount(input logic [POPC_W-1:0] v);
        logic [POPC_CNT_W-1:0] cnt;
        cnt = {POPC_CNT_W{1'b0}};
        for (int i = 0; i < POPC_W; i++) begin
            cnt = cnt + {{(POPC_CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vx_commit_unit_arbiter.sv
// Round-robin arbiter with a registered search pointer.
// The grant is combinational. The pointer advances past the winner only when
// a grant is actually issued.
module vx_rr_arbiter
    import vx_commit_pkg::*;
#(
    parameter int N = 6,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_valid_s;

    // Search from ptr_q upward, wrapping modulo N, and pick the first requester.
    always_comb begin
        int           pos;
        logic [IDX_W-1:0] pos_v;
        grant_s       = {N{1'b0}};
        grant_idx_s   = {IDX_W{1'b0}};
        grant_valid_s = 1'b0;
        pos           = 0;
        pos_v         = {IDX_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end else begin
                pos = pos;
            end
            pos_v = IDX_W'(pos);
            if (enable && !grant_valid_s && req[pos_v]) begin
                grant_valid_s  = 1'b1;
                grant_idx_s    = pos_v;
                grant_s[pos_v] = 1'b1;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // The next pointer sits one past the winner, so the winner gets the lowest priority next time.
    always_comb begin
        int nxt;
        nxt = int'(grant_idx_s) + 1;
        if (!grant_valid_s) begin
            ptr_d = ptr_q;
        end else if (nxt >= N) begin
            ptr_d = {IDX_W{1'b0}};
        end else begin
            ptr_d = IDX_W'(nxt);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant       = grant_s;
    assign grant_idx   = grant_idx_s;
    assign grant_valid = grant_valid_s;

endmodule

// File: rtl/vx_commit_unit.sv
// Commit stage. Writeback-bearing commits are merged round-robin into one
// registered writeback port. Store-like and no-writeback commits are accepted
// immediately. Per-cycle thread counts and the retired-thread counter are
// kept alongside.
module vx_commit_unit
    import vx_commit_pkg::*;
#(
    parameter int NUM_CH      = 6,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int DATA_W      = 32,
    parameter logic [NUM_CH-1:0] NOWB_MASK = 6'b000100,
    localparam int WID_W = wid_width(NUM_WARPS),
    localparam int CSZ_W = csz_width(NUM_CH, NUM_THREADS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    commit_valid,
    output logic [NUM_CH-1:0]                    commit_ready,
    input  logic [NUM_CH*WID_W-1:0]              commit_wid,
    input  logic [NUM_CH*NUM_THREADS-1:0]        commit_tmask,
    input  logic [NUM_CH-1:0]                    commit_wb,
    input  logic [NUM_CH*5-1:0]                  commit_rd,
    input  logic [NUM_CH*NUM_THREADS*DATA_W-1:0] commit_data,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [WID_W-1:0]                     wb_wid,
    output logic [NUM_THREADS-1:0]               wb_tmask,
    output logic [4:0]                           wb_rd,
    output logic [NUM_THREADS*DATA_W-1:0]        wb_data,
    output logic                                 cmt_valid,
    output logic [CSZ_W-1:0]                     cmt_size,
    output logic [63:0]                          instret
);

    localparam int IDX_W   = idx_width(NUM_CH);
    localparam int TDATA_W = NUM_THREADS * DATA_W;

    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [4:0]             rd;
        logic [TDATA_W-1:0]     data;
    } wb_entry_t;

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] bypass_s;
    logic [NUM_CH-1:0] grant_s;
    logic [NUM_CH-1:0] fire_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_valid_s;
    logic              load_s;
    logic              arb_en_s;

    wb_entry_t sel_s;
    wb_entry_t entry_q;
    wb_entry_t entry_d;
    logic      wb_valid_q;
    logic      wb_valid_d;

    logic [POPC_W-1:0]     fired_threads_s;
    logic [POPC_CNT_W-1:0] fired_cnt_s;
    logic                  cmt_valid_q;
    logic                  cmt_valid_d;
    logic [CSZ_W-1:0]      cmt_size_q;
    logic [CSZ_W-1:0]      cmt_size_d;
    logic [63:0]           instret_q;
    logic [63:0]           instret_d;

    // Split each channel into the bypass class or the arbitrated class.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bypass_s[i] = NOWB_MASK[i] | ~commit_wb[i];
            req_s[i]    = commit_valid[i] & commit_wb[i] & ~NOWB_MASK[i];
        end
    end

    // The output slot can take a new entry when it is empty or is being drained.
    // Arbitration is suppressed during reset so that no commit is lost.
    assign load_s   = ~wb_valid_q | wb_ready;
    assign arb_en_s = load_s & ~reset;

    vx_rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req_s),
        .enable      (arb_en_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    assign commit_ready = bypass_s | grant_s;
    assign fire_s       = commit_valid & commit_ready;

    // Select the granted channel's fields for capture into the output slot.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx_s == IDX_W'(i)) begin
                sel_s.wid   = commit_wid[i*WID_W +: WID_W];
                sel_s.tmask = commit_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_s.rd    = commit_rd[i*5 +: 5];
                sel_s.data  = commit_data[i*TDATA_W +: TDATA_W];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Output slot next state: capture on a grant, drain when loadable and idle, otherwise hold.
    always_comb begin
        entry_d    = entry_q;
        wb_valid_d = wb_valid_q;
        if (grant_valid_s) begin
            entry_d    = sel_s;
            wb_valid_d = 1'b1;
        end else if (load_s) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end
    end

    // Output slot registers. A pending entry is discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q    <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // Count the threads retired this cycle over every fired channel, bypass or arbitrated.
    always_comb begin
        fired_threads_s = {POPC_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            fired_threads_s[i*NUM_THREADS +: NUM_THREADS] =
                commit_tmask[i*NUM_THREADS +: NUM_THREADS] & {NUM_THREADS{fire_s[i]}};
        end
        fired_cnt_s = popcount(fired_threads_s);
        cmt_valid_d = |fire_s;
        cmt_size_d  = CSZ_W'(fired_cnt_s);
        instret_d   = cmt_valid_q ? (instret_q + 64'(cmt_size_q)) : instret_q;
    end

    // Statistics and retired-thread counter registers. The counter wraps modulo 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmt_valid_q <= 1'b0;
            cmt_size_q  <= {CSZ_W{1'b0}};
            instret_q   <= 64'd0;
        end else begin
            cmt_valid_q <= cmt_valid_d;
            cmt_size_q  <= cmt_size_d;
            instret_q   <= instret_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_wid    = entry_q.wid;
    assign wb_tmask  = entry_q.tmask;
    assign wb_rd     = entry_q.rd;
    assign wb_data   = entry_q.data;
    assign cmt_valid = cmt_valid_q;
    assign cmt_size  = cmt_size_q;
    assign instret   = instret_q;

endmodule
